// File: rtl/display_pkg.sv
// Shared 720p display constants and the motion-controller state type.
// No logic; no latency; no flow control.
package display_pkg;

   localparam int CORDW = 12;
   localparam int H_RES = 1280;
   localparam int V_RES = 720;

   typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} motion_state_t;

endpackage

// File: rtl/axis_bounce.sv
// One-axis step-and-bounce: moves pos by SPEED in dir, clamping at 0 / limit.
// Purely combinational; no flow control.
module axis_bounce
   import display_pkg::*;
#(
   parameter int SPEED = 2
) (
   input  logic [CORDW-1:0] pos,
   input  logic             dir,
   input  logic [CORDW-1:0] limit,
   output logic [CORDW-1:0] next_pos,
   output logic             next_dir,
   output logic             hit
);

   localparam int             CW1  = CORDW + 1;
   localparam logic [CW1-1:0] STEP = CW1'(SPEED);

   logic [CW1-1:0]   pos_w;
   logic [CW1-1:0]   fwd_w;
   logic [CORDW-1:0] back;

   always_comb begin
      // One extra bit so the forward sum can never wrap past the limit
      pos_w    = {1'b0, pos};
      fwd_w    = pos_w + STEP;
      back     = pos - STEP[CORDW-1:0];
      next_pos = pos;
      next_dir = dir;
      hit      = 1'b0;
      if (dir) begin
         if (fwd_w > {1'b0, limit}) begin
            next_pos = limit;
            next_dir = 1'b0;
            hit      = 1'b1;
         end else begin
            next_pos = fwd_w[CORDW-1:0];
         end
      end else begin
         if (pos_w < STEP) begin
            next_pos = '0;
            next_dir = 1'b1;
            hit      = 1'b1;
         end else begin
            next_pos = back;
         end
      end
   end

endmodule

// File: rtl/square_motion_ctrl.sv
// Bouncing-square position controller; optional hit counter under SQUARE_MOTION_CTRL_HITCNT_EN.
// Latency: update/sq_x/sq_y 3 cycles after the frame event; square 1 cycle after sx/sy.
// No backpressure: driven purely by display timing, one update per FRAME_DIV frames.
module square_motion_ctrl
   import display_pkg::*;
#(
   parameter int SIZE      = 400,
   parameter int SPEED     = 2,
   parameter int FRAME_DIV = 1
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic             de,
   input  logic             run,
   output logic             square,
   output logic [CORDW-1:0] sq_x,
   output logic [CORDW-1:0] sq_y,
   output logic             update,
   output logic             hit_x,
   output logic             hit_y
`ifdef SQUARE_MOTION_CTRL_HITCNT_EN
   ,
   output logic [7:0]       hit_cnt
`endif
);

   localparam int               CW1      = CORDW + 1;
   localparam logic [CORDW-1:0] LIM_X    = CORDW'(H_RES - SIZE);
   localparam logic [CORDW-1:0] LIM_Y    = CORDW'(V_RES - SIZE);
   localparam logic [CORDW-1:0] X_RST    = CORDW'((H_RES - SIZE) / 2);
   localparam logic [CORDW-1:0] Y_RST    = CORDW'((V_RES - SIZE) / 2);
   localparam logic [CORDW-1:0] V_BLANK  = CORDW'(V_RES);
   localparam logic [CW1-1:0]   SIZE_W   = CW1'(SIZE);
   localparam logic [7:0]       DIV_LAST = 8'(FRAME_DIV - 1);

   motion_state_t    state_q, state_d;
   logic [7:0]       div_q, div_d;
   logic [CORDW-1:0] shx_q, shx_d, shy_q, shy_d;
   logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic             hxp_q, hxp_d, hyp_q, hyp_d;
   logic [CORDW-1:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
   logic             upd_q, upd_d, hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic             square_q, square_d;
   logic             frame_evt;
   logic             de_unused;

   logic [CORDW-1:0] bx_pos, by_pos;
   logic             bx_dir, by_dir, bx_hit, by_hit;

   assign de_unused = de;
   assign frame_evt = (sx == '0) && (sy == V_BLANK);

   axis_bounce #(.SPEED(SPEED)) u_bounce_x (
      .pos      (sq_x_q),
      .dir      (dir_x_q),
      .limit    (LIM_X),
      .next_pos (bx_pos),
      .next_dir (bx_dir),
      .hit      (bx_hit)
   );

   axis_bounce #(.SPEED(SPEED)) u_bounce_y (
      .pos      (sq_y_q),
      .dir      (dir_y_q),
      .limit    (LIM_Y),
      .next_pos (by_pos),
      .next_dir (by_dir),
      .hit      (by_hit)
   );

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      shx_d    = shx_q;
      shy_d    = shy_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      hxp_d    = hxp_q;
      hyp_d    = hyp_q;
      sq_x_d   = sq_x_q;
      sq_y_d   = sq_y_q;
      upd_d    = 1'b0;
      hit_x_d  = 1'b0;
      hit_y_d  = 1'b0;
      square_d = ({1'b0, sx} >= {1'b0, sq_x_q}) && ({1'b0, sx} < ({1'b0, sq_x_q} + SIZE_W)) &&
                 ({1'b0, sy} >= {1'b0, sq_y_q}) && ({1'b0, sy} < ({1'b0, sq_y_q} + SIZE_W));
      unique case (state_q)
         IDLE: begin
            if (frame_evt && run) begin
               if (div_q == DIV_LAST) begin
                  div_d   = '0;
                  state_d = CALC_X;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
         end
         CALC_X: begin
            shx_d   = bx_pos;
            dir_x_d = bx_dir;
            hxp_d   = bx_hit;
            state_d = CALC_Y;
         end
         CALC_Y: begin
            shy_d   = by_pos;
            dir_y_d = by_dir;
            hyp_d   = by_hit;
            state_d = COMMIT;
         end
         COMMIT: begin
            // Both axes land in the same cycle so the visible image never tears
            sq_x_d  = shx_q;
            sq_y_d  = shy_q;
            upd_d   = 1'b1;
            hit_x_d = hxp_q;
            hit_y_d = hyp_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state_q  <= IDLE;
         div_q    <= '0;
         shx_q    <= X_RST;
         shy_q    <= Y_RST;
         dir_x_q  <= 1'b1;
         dir_y_q  <= 1'b1;
         hxp_q    <= 1'b0;
         hyp_q    <= 1'b0;
         sq_x_q   <= X_RST;
         sq_y_q   <= Y_RST;
         upd_q    <= 1'b0;
         hit_x_q  <= 1'b0;
         hit_y_q  <= 1'b0;
         square_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         shx_q    <= shx_d;
         shy_q    <= shy_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         hxp_q    <= hxp_d;
         hyp_q    <= hyp_d;
         sq_x_q   <= sq_x_d;
         sq_y_q   <= sq_y_d;
         upd_q    <= upd_d;
         hit_x_q  <= hit_x_d;
         hit_y_q  <= hit_y_d;
         square_q <= square_d;
      end
   end

   assign square = square_q;
   assign sq_x   = sq_x_q;
   assign sq_y   = sq_y_q;
   assign update = upd_q;
   assign hit_x  = hit_x_q;
   assign hit_y  = hit_y_q;

`ifdef SQUARE_MOTION_CTRL_HITCNT_EN
   logic [7:0] hit_cnt_q, hit_cnt_d;

   always_comb begin
      hit_cnt_d = hit_cnt_q;
      // A corner bounce counts once; the counter sticks at 255
      if ((state_q == COMMIT) && (hxp_q || hyp_q) && (hit_cnt_q != 8'hFF)) begin
         hit_cnt_d = hit_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         hit_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Randomized bench for square_motion_ctrl: two instances (FRAME_DIV 1 and 3) against a behavioural model.
module tb_square_motion_ctrl;

   localparam int HR = 1280;
   localparam int VR = 720;
   localparam int SZ = 400;
   localparam int SP = 2;

   logic        clk_pix = 1'b0;
   logic        rst_pix = 1'b0;
   logic [11:0] sx = 12'd100;
   logic [11:0] sy = 12'd100;
   logic        de = 1'b0;
   logic        run = 1'b1;

   logic        sq_o   [2];
   logic [11:0] sqx_o  [2];
   logic [11:0] sqy_o  [2];
   logic        upd_o  [2];
   logic        hx_o   [2];
   logic        hy_o   [2];
`ifdef SQUARE_MOTION_CTRL_HITCNT_EN
   logic [7:0]  cnt_o  [2];
`endif

   square_motion_ctrl dut (
      .clk_pix (clk_pix), .rst_pix (rst_pix), .sx (sx), .sy (sy), .de (de), .run (run),
      .square (sq_o[0]), .sq_x (sqx_o[0]), .sq_y (sqy_o[0]),
      .update (upd_o[0]), .hit_x (hx_o[0]), .hit_y (hy_o[0])
`ifdef SQUARE_MOTION_CTRL_HITCNT_EN
      , .hit_cnt (cnt_o[0])
`endif
   );

   square_motion_ctrl #(.FRAME_DIV(3)) dut3 (
      .clk_pix (clk_pix), .rst_pix (rst_pix), .sx (sx), .sy (sy), .de (de), .run (run),
      .square (sq_o[1]), .sq_x (sqx_o[1]), .sq_y (sqy_o[1]),
      .update (upd_o[1]), .hit_x (hx_o[1]), .hit_y (hy_o[1])
`ifdef SQUARE_MOTION_CTRL_HITCNT_EN
      , .hit_cnt (cnt_o[1])
`endif
   );

   always #5 clk_pix = ~clk_pix;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int fdiv [2] = '{1, 3};
   int mx [2], my [2], mdx [2], mdy [2], mdiv [2], pend [2];
   int px [2], py [2], pdx [2], pdy [2], phx [2], phy [2];
   int e_sq [2], e_upd [2], e_hx [2], e_hy [2], e_cnt [2];

   function automatic void bounce(input int p, input int d, input int lim,
                                  output int np, output int nd, output int h);
      np = p + d * SP;
      nd = d;
      h  = 0;
      if (np > lim) begin
         np = lim; nd = -d; h = 1;
      end else if (np < 0) begin
         np = 0; nd = -d; h = 1;
      end
   endfunction

   task automatic model_reset(input int i);
      mx[i] = (HR - SZ) / 2; my[i] = (VR - SZ) / 2;
      mdx[i] = 1; mdy[i] = 1; mdiv[i] = 0; pend[i] = 0;
      e_sq[i] = 0; e_upd[i] = 0; e_hx[i] = 0; e_hy[i] = 0; e_cnt[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) model_reset(i);
      forever begin
         @(posedge clk_pix or posedge rst_pix);
         for (int i = 0; i < 2; i++) begin
            if (rst_pix) begin
               model_reset(i);
            end else begin
               automatic bit busy = (pend[i] != 0);
               e_sq[i] = (int'(sx) >= mx[i] && int'(sx) < mx[i] + SZ &&
                          int'(sy) >= my[i] && int'(sy) < my[i] + SZ) ? 1 : 0;
               e_upd[i] = 0; e_hx[i] = 0; e_hy[i] = 0;
               if (busy) begin
                  pend[i]--;
                  if (pend[i] == 0) begin
                     mx[i] = px[i]; my[i] = py[i]; mdx[i] = pdx[i]; mdy[i] = pdy[i];
                     e_upd[i] = 1; e_hx[i] = phx[i]; e_hy[i] = phy[i];
                     if ((phx[i] | phy[i]) != 0 && e_cnt[i] < 255) e_cnt[i]++;
                  end
               end
               if (!busy && sx == 0 && int'(sy) == VR && run) begin
                  if (mdiv[i] == fdiv[i] - 1) begin
                     mdiv[i] = 0;
                     bounce(mx[i], mdx[i], HR - SZ, px[i], pdx[i], phx[i]);
                     bounce(my[i], mdy[i], VR - SZ, py[i], pdy[i], phy[i]);
                     pend[i] = 3;
                  end else begin
                     mdiv[i]++;
                  end
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int n_upd [2] = '{0, 0};
   int last_x = 0, last_y = 0, last_hx = 0, last_hy = 0;

   initial begin
      #2;
      forever begin
         @(negedge clk_pix);
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("sq_x[%0d]", i), int'(sqx_o[i]), mx[i]);
            chk($sformatf("sq_y[%0d]", i), int'(sqy_o[i]), my[i]);
            chk($sformatf("update[%0d]", i), int'(upd_o[i]), e_upd[i]);
            chk($sformatf("hit_x[%0d]", i), int'(hx_o[i]), e_hx[i]);
            chk($sformatf("hit_y[%0d]", i), int'(hy_o[i]), e_hy[i]);
            chk($sformatf("square[%0d]", i), int'(sq_o[i]), e_sq[i]);
`ifdef SQUARE_MOTION_CTRL_HITCNT_EN
            chk($sformatf("hit_cnt[%0d]", i), int'(cnt_o[i]), e_cnt[i]);
`endif
            if (upd_o[i]) n_upd[i]++;
         end
         if (upd_o[0]) begin
            last_x = int'(sqx_o[0]); last_y = int'(sqy_o[0]);
            last_hx = int'(hx_o[0]); last_hy = int'(hy_o[0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic frame(input bit r);
      sx = 12'd0; sy = 12'(VR); run = r; de = 1'b0;
      @(negedge clk_pix);
      repeat (5) begin
         sx = 12'($urandom_range(0, HR - 1));
         sy = 12'($urandom_range(0, VR - 1));
         de = 1'b1;
         @(negedge clk_pix);
      end
   endtask

   task automatic pix(input int x, input int y, input int exp, input string name);
      sx = 12'(x); sy = 12'(y);
      @(negedge clk_pix);
      chk(name, int'(sq_o[0]), exp);
   endtask

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
   endtask

   initial begin
      #600000;
      fails++;
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      summary();
      $fatal(1);
   end

   initial begin
      int u0, x0, y0, guard, cnt0;
      #1 rst_pix = 1'b1;
      repeat (3) @(negedge clk_pix);
      rst_pix = 1'b0;
      chk("reset sq_x", int'(sqx_o[0]), 440);
      chk("reset sq_y", int'(sqy_o[0]), 160);
      chk("reset update", int'(upd_o[0]), 0);

      pix(440, 160, 1, "pix 440,160");
      pix(839, 559, 1, "pix 839,559");
      pix(839, 560, 0, "pix 839,560");
      pix(840, 160, 0, "pix 840,160");
      pix(439, 300, 0, "pix 439,300");
      chk("no update before frame", n_upd[0], 0);

      frame(1'b1);
      chk("first update count", n_upd[0], 1);
      chk("first sq_x", last_x, 442);
      chk("first sq_y", last_y, 162);
      chk("first hit_x", last_hx, 0);
      chk("first hit_y", last_hy, 0);
      chk("div3 after 1 frame", n_upd[1], 0);
      frame(1'b1);
      chk("div3 after 2 frames", n_upd[1], 0);
      frame(1'b1);
      chk("div3 after 3 frames", n_upd[1], 1);

      repeat (216) frame(1'b1);
      chk("approach sq_x", last_x, 878);
      frame(1'b1);
      chk("edge sq_x", last_x, 880);
      chk("edge no hit", last_hx, 0);
      frame(1'b1);
      chk("bounce sq_x", last_x, 880);
      chk("bounce hit_x", last_hx, 1);
      frame(1'b1);
      chk("return sq_x", last_x, 878);
      chk("return hit_x", last_hx, 0);

      u0 = n_upd[0]; x0 = int'(sqx_o[0]); y0 = int'(sqy_o[0]);
      repeat (5) frame(1'b0);
      chk("hold no update", n_upd[0], u0);
      chk("hold sq_x", int'(sqx_o[0]), x0);
      chk("hold sq_y", int'(sqy_o[0]), y0);

      guard = 0;
      while (n_upd[0] < 5071 && guard < 8000) begin
         frame($urandom_range(0, 7) != 0);
         guard++;
      end
      chk("reached pre-corner", n_upd[0], 5071);

      cnt0 = e_cnt[0];
      frame(1'b1);
      chk("corner sq_x", last_x, 0);
      chk("corner sq_y", last_y, 0);
      chk("corner hit_x", last_hx, 1);
      chk("corner hit_y", last_hy, 1);
`ifdef SQUARE_MOTION_CTRL_HITCNT_EN
      chk("corner hit_cnt step", int'(cnt_o[0]), cnt0 + 1);
`endif
      frame(1'b1);
      chk("after corner sq_x", last_x, 2);
      chk("after corner sq_y", last_y, 2);

      u0 = n_upd[0];
      sx = 12'd0; sy = 12'(VR); run = 1'b1;
      @(negedge clk_pix);
      sx = 12'd5; sy = 12'd5;
      @(negedge clk_pix);
      rst_pix = 1'b1;
      @(negedge clk_pix);
      chk("midreset sq_x", int'(sqx_o[0]), 440);
      chk("midreset sq_y", int'(sqy_o[0]), 160);
      chk("midreset update", int'(upd_o[0]), 0);
      rst_pix = 1'b0;
      repeat (4) @(negedge clk_pix);
      chk("midreset no commit", n_upd[0], u0);
      frame(1'b1);
      chk("post-reset sq_x", last_x, 442);
      repeat (20) frame($urandom_range(0, 3) != 0);

      summary();
      $finish;
   end

endmodule
